// File: rtl/data_bus_responder_if.sv
// Data-bus interface between the datapath and the data-memory responder.
// Carries request address/data/strobes, error-clear and all responder status outputs.
// master = datapath side (drives requests), slave = responder side (drives read data/status).
interface data_bus_responder_if;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic        iWriteEnable;
    logic        iReadEnable;
    logic [3:0]  iByteEnable;
    logic        iErrClear;
    logic [31:0] oReadData;
    logic        oBusy;
    logic        oError;
    logic [2:0]  oErrCode;
    logic [31:0] oErrAddr;
    logic [15:0] oReadCount;
    logic [15:0] oWriteCount;

    modport master (
        output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable, iErrClear,
        input  oReadData, oBusy, oError, oErrCode, oErrAddr, oReadCount, oWriteCount
    );

    modport slave (
        input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable, iErrClear,
        output oReadData, oBusy, oError, oErrCode, oErrAddr, oReadCount, oWriteCount
    );
endinterface

// File: rtl/data_bus_responder.sv
// Word-addressed data memory responder with post-reset clear sweep, sticky error capture and counters.
// Latency: writes land at the request edge; reads return one cycle later on oReadData.
// Backpressure: none; requests while oBusy is high are rejected (error 4), not stalled.
// Ports: iCLK, iRST (sync, active-high) plain; bus (slave modport) carries requests and status.
module data_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic           iCLK,
    input  logic           iRST,
    data_bus_responder_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;
    logic [31:0]     eaddr_q, eaddr_d;
    logic [15:0]     rcnt_q, rcnt_d;
    logic [15:0]     wcnt_q, wcnt_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            hit;
    logic            legal_mask;
    logic            req;
    logic [AW-1:0]   word_idx;
    logic [3:0]      mem_be;
    logic [AW-1:0]   mem_widx;
    logic [31:0]     mem_wdat;
    logic            err_vld;
    logic [2:0]      err_code;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign hit      = (33'(bus.iAddress) >= 33'(BASE_ADDR)) && (33'(bus.iAddress) < END_ADDR);
    assign word_idx = AW'((bus.iAddress - BASE_ADDR) >> 2);
    assign req      = bus.iReadEnable | bus.iWriteEnable;

    // Only naturally aligned byte, halfword and word strobes are legal.
    assign legal_mask = (bus.iByteEnable == 4'b0001) || (bus.iByteEnable == 4'b0010) ||
                        (bus.iByteEnable == 4'b0100) || (bus.iByteEnable == 4'b1000) ||
                        (bus.iByteEnable == 4'b0011) || (bus.iByteEnable == 4'b1100) ||
                        (bus.iByteEnable == 4'b1111);

    // State register. Reset is synchronous and folded into the _d logic.
    always_ff @(posedge iCLK) begin
        state_q <= state_d;
        idx_q   <= idx_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
        code_q  <= code_d;
        eaddr_q <= eaddr_d;
        rcnt_q  <= rcnt_d;
        wcnt_q  <= wcnt_d;
    end

    // Storage: per-lane write so partial stores leave other lanes untouched.
    always_ff @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
                mem_q[mem_widx][8*b +: 8] <= mem_wdat[8*b +: 8];
            end
        end
    end

    // Next-state logic: sweep every word once, then stay ready until reset.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (iRST) begin
            state_d = S_CLEAR;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == AW'(DEPTH_WORDS - 1)) begin
                        state_d = S_READY;
                    end
                end
                default: state_d = S_READY;
            endcase
        end
    end

    // Output / datapath logic.
    always_comb begin
        rdata_d  = rdata_q;
        err_d    = err_q;
        code_d   = code_q;
        eaddr_d  = eaddr_q;
        rcnt_d   = rcnt_q;
        wcnt_d   = wcnt_q;
        mem_be   = 4'b0000;
        mem_widx = word_idx;
        mem_wdat = bus.iWriteData;
        err_vld  = 1'b0;
        err_code = 3'd0;

        if (iRST) begin
            rdata_d = '0;
            err_d   = 1'b0;
            code_d  = 3'd0;
            eaddr_d = '0;
            rcnt_d  = '0;
            wcnt_d  = '0;
        end else begin
            if (state_q == S_CLEAR) begin
                mem_be   = 4'b1111;
                mem_widx = idx_q;
                mem_wdat = '0;
                if (req) begin
                    rdata_d  = '0;
                    err_vld  = 1'b1;
                    err_code = 3'd4;
                end
            end else if (req && !hit) begin
                if (bus.iReadEnable) begin
                    rdata_d = '0;
                end
                err_vld  = 1'b1;
                err_code = 3'd1;
            end else if (bus.iWriteEnable) begin
                if (legal_mask) begin
                    mem_be = bus.iByteEnable;
                    if (wcnt_q != 16'hFFFF) begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end else begin
                    err_vld  = 1'b1;
                    err_code = 3'd2;
                end
                // Collision outranks a bad mask; the read half is dropped.
                if (bus.iReadEnable) begin
                    err_vld  = 1'b1;
                    err_code = 3'd3;
                end
            end else if (bus.iReadEnable) begin
                rdata_d = mem_q[word_idx];
                if (rcnt_q != 16'hFFFF) begin
                    rcnt_d = rcnt_q + 16'd1;
                end
            end

            // First error sticks; a clear in the same cycle makes room for the new one.
            if (err_vld && (!err_q || bus.iErrClear)) begin
                err_d   = 1'b1;
                code_d  = err_code;
                eaddr_d = bus.iAddress;
            end else if (bus.iErrClear) begin
                err_d   = 1'b0;
                code_d  = 3'd0;
                eaddr_d = '0;
            end
        end
    end

    assign bus.oReadData   = rdata_q;
    assign bus.oBusy       = (state_q == S_CLEAR);
    assign bus.oError      = err_q;
    assign bus.oErrCode    = code_q;
    assign bus.oErrAddr    = eaddr_q;
    assign bus.oReadCount  = rcnt_q;
    assign bus.oWriteCount = wcnt_q;
endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: randomized and directed traffic vs. a behavioural model.
// Model and DUT are compared after every clock edge; directed checks pin known literal results.
// Single driving process; all waits are bounded by fixed cycle counts.
module tb_data_bus_responder;
    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 256;

    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    data_bus_responder_if bus();

    data_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    // Behavioural model state.
    logic [31:0] m_mem [DEPTH];
    int          m_busy_left;
    logic [31:0] m_rd;
    logic        m_err;
    logic [2:0]  m_code;
    logic [31:0] m_eaddr;
    int          m_rc;
    int          m_wc;

    bit chk_en = 1'b0;
    int total  = 0;
    int bad    = 0;

    logic [3:0] legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    function automatic bit is_legal(input logic [3:0] m);
        return (m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Computes the model's post-edge state from the inputs presented before the edge.
    task automatic model_step();
        longint a;
        bit     hit;
        bit     busy;
        int     idx;
        int     code;
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_busy_left = DEPTH;
            m_rd = '0; m_err = 1'b0; m_code = 3'd0; m_eaddr = '0; m_rc = 0; m_wc = 0;
            return;
        end
        a    = {32'h0, bus.iAddress};
        hit  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
        idx  = hit ? int'((a - longint'(BASE)) / 4) : 0;
        busy = (m_busy_left > 0);
        code = 0;
        if (busy) begin
            if (bus.iReadEnable || bus.iWriteEnable) begin
                m_rd = '0;
                code = 4;
            end
        end else if ((bus.iReadEnable || bus.iWriteEnable) && !hit) begin
            if (bus.iReadEnable) m_rd = '0;
            code = 1;
        end else if (bus.iWriteEnable) begin
            if (is_legal(bus.iByteEnable)) begin
                for (int b = 0; b < 4; b++)
                    if (bus.iByteEnable[b]) m_mem[idx][8*b +: 8] = bus.iWriteData[8*b +: 8];
                if (m_wc < 65535) m_wc++;
            end else begin
                code = 2;
            end
            if (bus.iReadEnable) code = 3;
        end else if (bus.iReadEnable) begin
            m_rd = m_mem[idx];
            if (m_rc < 65535) m_rc++;
        end
        if (code != 0 && (!m_err || bus.iErrClear)) begin
            m_err = 1'b1; m_code = 3'(code); m_eaddr = bus.iAddress;
        end else if (bus.iErrClear) begin
            m_err = 1'b0; m_code = 3'd0; m_eaddr = '0;
        end
        if (m_busy_left > 0) m_busy_left--;
    endtask

    task automatic compare_all();
        check("read_data",   bus.oReadData,          m_rd);
        check("busy",        32'(bus.oBusy),         32'(m_busy_left > 0));
        check("error",       32'(bus.oError),        32'(m_err));
        check("err_code",    32'(bus.oErrCode),      32'(m_code));
        check("err_addr",    bus.oErrAddr,           m_eaddr);
        check("read_count",  32'(bus.oReadCount),    32'(m_rc));
        check("write_count", 32'(bus.oWriteCount),   32'(m_wc));
    endtask

    // One clock: model, edge, then compare away from the edge.
    task automatic cyc();
        model_step();
        @(posedge iCLK);
        #1;
        if (iRST) chk_en = 1'b1;
        if (chk_en) compare_all();
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re,
                      input logic [3:0] be, input logic clr, input logic rst);
        bus.iAddress = a; bus.iWriteData = d; bus.iWriteEnable = we; bus.iReadEnable = re;
        bus.iByteEnable = be; bus.iErrClear = clr; iRST = rst;
        cyc();
        bus.iWriteEnable = 1'b0; bus.iReadEnable = 1'b0; bus.iErrClear = 1'b0; iRST = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Counts cycles until busy drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.oBusy && n < 1000) begin
            idle(1);
            n++;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 4)       return BASE + 32'($urandom_range(0, 63));
        else if (sel < 7)  return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        else if (sel == 7) return BASE - 32'($urandom_range(1, 8));
        else if (sel == 8) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
        else               return $urandom;
    endfunction

    initial begin
        int n;
        logic [31:0] a;
        logic [3:0]  be;
        int kind;

        bus.iAddress = '0; bus.iWriteData = '0; bus.iWriteEnable = 1'b0; bus.iReadEnable = 1'b0;
        bus.iByteEnable = '0; bus.iErrClear = 1'b0; iRST = 1'b1;

        // Reset with requests and clear pending: reset must win.
        op(BASE, 32'hFFFFFFFF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
        op(BASE, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("rst_busy",   32'(bus.oBusy), 32'd1);
        check("rst_rdata",  bus.oReadData, 32'h0);
        check("rst_error",  32'(bus.oError), 32'd0);
        check("rst_rcount", 32'(bus.oReadCount), 32'd0);

        count_busy(n);
        check("sweep_len", 32'(n), 32'd256);

        op(32'h100100FC, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("cleared_word", bus.oReadData, 32'h0);

        op(32'h10010010, 32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
        op(32'h10010010, 32'h00AA0000, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
        op(32'h10010013, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("byte_merge", bus.oReadData, 32'hDEAABEEF);
        check("wcount_2",   32'(bus.oWriteCount), 32'd2);
        check("rcount_2",   32'(bus.oReadCount), 32'd2);  // includes the cleared-word read

        op(32'h10010400, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("miss_rdata", bus.oReadData, 32'h0);
        check("miss_err",   32'(bus.oError), 32'd1);
        check("miss_code",  32'(bus.oErrCode), 32'd1);
        check("miss_addr",  bus.oErrAddr, 32'h10010400);
        op(32'h10010010, 32'h0, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
        check("sticky_code", 32'(bus.oErrCode), 32'd1);
        op(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("cleared_err", 32'(bus.oError), 32'd0);

        op(32'h10010010, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        op(32'h10010020, 32'h12345678, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        check("both_hold", bus.oReadData, 32'hDEAABEEF);
        check("both_code", 32'(bus.oErrCode), 32'd3);
        op(32'h10010020, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("both_wrote", bus.oReadData, 32'h12345678);
        op(32'h10010020, 32'h12345678, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0);
        check("clr_same_err",  32'(bus.oError), 32'd1);
        check("clr_same_code", 32'(bus.oErrCode), 32'd3);
        op(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

        op(32'h10010020, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("mask0_code", 32'(bus.oErrCode), 32'd2);
        op(32'h10010020, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("mask0_nowrite", bus.oReadData, 32'h12345678);
        op(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

        // Randomized traffic; occasional resets exercise the sweep again.
        for (int i = 0; i < 4000; i++) begin
            a    = rand_addr();
            be   = ($urandom_range(0, 9) < 8) ? legal_list[$urandom_range(0, 6)] : 4'($urandom);
            kind = $urandom_range(0, 9);
            op(a, $urandom, (kind <= 3) || (kind == 7), (kind >= 4 && kind <= 7), be,
               (kind == 9) || ($urandom_range(0, 19) == 0), ($urandom_range(0, 999) == 0));
        end

        // Request during sweep, then a reset at sweep index 100.
        op(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        idle(49);
        op(BASE, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("clear_req_code",  32'(bus.oErrCode), 32'd4);
        check("clear_req_rdata", bus.oReadData, 32'h0);
        idle(50);
        check("still_busy", 32'(bus.oBusy), 32'd1);
        op(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        count_busy(n);
        check("restart_len", 32'(n), 32'd256);

        for (int i = 0; i < 65537; i++)
            op(BASE + 32'($urandom_range(0, 4 * DEPTH - 1)), 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        check("rcount_sat", 32'(bus.oReadCount), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 16 to 4096.
REQ-003 iCLK  input  1  clock; all state changes on rising edge.
REQ-004 iRST  input  1  reset, synchronous, active-high.
REQ-005 iAddress  input  32  byte address from the datapath data bus.
REQ-006 iWriteData  input  32  lane-aligned store data.
REQ-007 iWriteEnable  input  1  write request, sampled each edge.
REQ-008 iReadEnable  input  1  read request, sampled each edge.
REQ-009 iByteEnable  input  4  write lane mask; bit n selects bits [8n+7:8n].
REQ-010 iErrClear  input  1  clears sticky error state.
REQ-011 oReadData  output  32  registered read word.
REQ-012 oBusy  output  1  high while the post-reset clear sweep runs.
REQ-013 oError  output  1  sticky error flag.
REQ-014 oErrCode  output  3  code of the first captured error.
REQ-015 oErrAddr  output  32  iAddress of the first captured error.
REQ-016 oReadCount, oWriteCount  output  16 each  saturating counts of accepted reads and accepted writes.

Function
REQ-017 Hit: BASE_ADDR <= iAddress < BASE_ADDR + 4*DEPTH_WORDS.
REQ-018 Word index: (iAddress - BASE_ADDR) >> 2. Address bits [1:0] are ignored.
REQ-019 FSM states: CLEAR and READY. Reset enters CLEAR with sweep index 0.
REQ-020 In CLEAR, one word per cycle is written to 0. The index increments; after index DEPTH_WORDS-1 the FSM enters READY on the next edge.
REQ-021 oBusy is 1 exactly while in CLEAR, so for DEPTH_WORDS cycles after reset deasserts.
REQ-022 Any request (iReadEnable or iWriteEnable) in CLEAR:
 - write is dropped;
 - oReadData is set to 0;
 - error code 3'd4 is recorded.
REQ-023 Legal byte-enable patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-024 Accepted write: READY, iWriteEnable, hit and legal mask. Only the enabled lanes are updated, at this edge. oWriteCount increments.
REQ-025 Write with an illegal mask, including 0000: memory is unchanged and error 3'd2 is recorded.
REQ-026 Accepted read: READY, iReadEnable, hit and iWriteEnable low. oReadData takes the word at the next edge (1-cycle latency). oReadCount increments.
REQ-027 When iReadEnable is low, oReadData holds its value.
REQ-028 A read of a word written on the previous edge returns the new data (no stale data).
REQ-029 Both iReadEnable and iWriteEnable high in READY:
 - the write is processed per REQ-024/025;
 - the read is ignored and oReadData holds;
 - error 3'd3 is recorded.
REQ-030 Miss in READY:
 - memory is unchanged;
 - oReadData is set to 0 if iReadEnable;
 - error 3'd1 is recorded.
REQ-031 Error priority in one cycle: 4 > 1 > 3 > 2.
REQ-032 Recording an error when oError=0 sets oError=1 and captures oErrCode and oErrAddr.
REQ-033 While oError=1, later errors do not change oErrCode or oErrAddr.
REQ-034 iErrClear clears oError, oErrCode and oErrAddr to 0. If an error is recorded in the same cycle, the new error is captured instead.
REQ-035 Counters stop at 16'hFFFF and do not wrap.

Reset
REQ-036 On iRST at an edge:
 - oReadData, oError, oErrCode, oErrAddr, oReadCount and oWriteCount become 0;
 - FSM enters CLEAR with index 0, so oBusy=1.
REQ-037 iRST asserted during CLEAR restarts the sweep at index 0.
REQ-038 Reset overrides all requests and iErrClear in that cycle.

Verification
REQ-039 Reset, then idle DEPTH_WORDS cycles -> oBusy falls after exactly 256 cycles. A read of 32'h100100FC then returns 0.
REQ-040 Write 32'hDEADBEEF with mask 1111 to 32'h10010010, then the next cycle a byte write 32'h00AA0000 with mask 0100, then a read -> oReadData=32'hDEAABEEF. oWriteCount=2, oReadCount=1.
REQ-041 Read of 32'h10010400 (miss) in READY:
 - oReadData=0, oError=1, oErrCode=1, oErrAddr=32'h10010400;
 - then a write with mask 0101 leaves oErrCode=1.
REQ-042 Read and write both high at 32'h10010020 with 32'h12345678, mask 1111:
 - memory updated and oReadData unchanged;
 - oErrCode=3.
 - With iErrClear also high the same cycle, oError=1 and oErrCode=3.
REQ-043 iRST asserted for one cycle at sweep index 100 -> oBusy stays high for 256 further cycles.
REQ-044 65537 accepted reads -> oReadCount=16'hFFFF.
